pixel_stream_feeder: RTL

- Transmit side of the line-buffer pixel interface. Reads a fixed-point image row by row from a synchronous-read frame memory and streams it into the 4-line-buffer window generator (imageControl-style block).
- Uses that block's per-line interrupt as a one-line credit, so no line buffer is ever overwritten before it has been consumed.
- Sits between the frame memory / loader and the window generator. Raises o_done when the whole frame has been consumed.

---
 rtl/pixel_stream_feeder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pixel_stream_feeder.sv
// Streams a frame from synchronous-read memory into a 4-line-buffer window generator,
// pacing whole lines with a credit counter fed by the downstream per-line interrupt.
module pixel_stream_feeder #(
    parameter int INTEGER_BITS     = 8,
    parameter int FIXED_POINT_BITS = 4,
    parameter int LINE_WIDTH       = 512,
    parameter int IMG_LINES        = 512,
    parameter int PREFILL_LINES    = 4,
    parameter int ADDR_W           = 18
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_start,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_mem_rd_en,
    output logic [ADDR_W-1:0]                        o_mem_addr,
    input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] i_mem_rd_data,
    output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] o_pixel_data,
    output logic                                     o_pixel_data_valid,
    input  logic                                     i_intr,
    output logic [2:0]                               dbg_state
);

    localparam int COL_W  = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int LINE_W = $clog2(IMG_LINES);
    localparam int ICNT_W = $clog2(IMG_LINES + 1);

    localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(LINE_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(IMG_LINES - 1);
    localparam logic [ICNT_W-1:0] INTR_TARGET = ICNT_W'(IMG_LINES - 2);
    localparam logic [3:0]        CREDIT_INIT = 4'(PREFILL_LINES);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SEND        = 3'd1,
        WAIT_CREDIT = 3'd2,
        DRAIN       = 3'd3,
        DONE        = 3'd4
    } state_t;

    state_t              state;
    logic [COL_W-1:0]    col;
    logic [LINE_W-1:0]   line;
    logic [3:0]          credit;
    logic [3:0]          credit_next;
    logic [ICNT_W-1:0]   intr_cnt;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                rd_en_d;
    logic                credit_take;
    logic                credit_give;

    assign dbg_state = state;

    // A line start and an interrupt in the same cycle cancel; credit saturates at 15.
    always_comb begin
        credit_take = (state == SEND) && (col == '0);
        credit_give = i_intr && (state != IDLE);
        credit_next = credit;
        if (credit_take && !credit_give && credit != 4'd0)
            credit_next = credit - 4'd1;
        else if (credit_give && !credit_take && credit != 4'hF)
            credit_next = credit + 4'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= IDLE;
            col                <= '0;
            line               <= '0;
            credit             <= '0;
            intr_cnt           <= '0;
            rd_ptr             <= '0;
            rd_en_d            <= 1'b0;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
            o_mem_rd_en        <= 1'b0;
            o_mem_addr         <= '0;
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
        end else begin
            o_mem_rd_en <= 1'b0;
            o_done      <= 1'b0;
            credit      <= credit_next;
            if (credit_give)
                intr_cnt <= intr_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state    <= SEND;
                        o_busy   <= 1'b1;
                        credit   <= CREDIT_INIT;
                        col      <= '0;
                        line     <= '0;
                        intr_cnt <= '0;
                        rd_ptr   <= '0;
                    end
                end
                SEND: begin
                    // Addresses are contiguous across lines, so a running pointer replaces line*W+col.
                    o_mem_rd_en <= 1'b1;
                    o_mem_addr  <= rd_ptr;
                    rd_ptr      <= rd_ptr + 1'b1;
                    if (col == COL_LAST) begin
                        col  <= '0;
                        line <= line + 1'b1;
                        if (line == LINE_LAST)
                            state <= DRAIN;
                        else if (credit_next == 4'd0)
                            state <= WAIT_CREDIT;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                WAIT_CREDIT: begin
                    if (credit != 4'd0)
                        state <= SEND;
                end
                DRAIN: begin
                    if (intr_cnt >= INTR_TARGET) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Two-stage return path: memory data lands one cycle after the strobe, then is registered.
            rd_en_d            <= o_mem_rd_en;
            o_pixel_data_valid <= rd_en_d;
            if (rd_en_d)
                o_pixel_data <= i_mem_rd_data;
        end
    end

endmodule
